// File: rtl/demodulate_pkg.sv
// Shared definitions for the AM/FM demodulator.
// Holds the FM lock-tracker state encoding, the carrier polarity encoding,
// the Sel mode constants and a small helper for rising-crossing detection.
package demodulate_pkg;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    MEAS = 2'd1,
    LOCK = 2'd2
  } fm_state_e;

  typedef enum logic {
    NEG = 1'b0,
    POS = 1'b1
  } polarity_e;

  localparam logic MODE_FM = 1'b1;
  localparam logic MODE_AM = 1'b0;

  // A rising zero crossing is a NEG -> POS polarity change.
  function automatic logic is_rising(input polarity_e prev, input polarity_e next);
    return (prev == NEG) && (next == POS);
  endfunction

endpackage

// File: rtl/demodulate_am_envelope.sv
// AM envelope detector: full-wave rectifier about mid-scale followed by a
// peak-hold with programmable exponential decay.
// Ports:
//   clk_in        clock, rising edge
//   rst_n         asynchronous active-low reset
//   clear         synchronous flush (mode change): drops in-flight data, env=0
//   sample_valid  wave_in carries an accepted AM sample this cycle
//   wave_in       offset-binary carrier sample
//   decay_shift   decay shift travelling with the sample (0 = load rect)
//   env           current envelope register (INPUT_WIDTH-1 bits)
//   env_next      value the envelope takes on this edge when env_update=1
//   env_update    stage-2 strobe: envelope is being updated this cycle
module am_envelope
  import demodulate_pkg::*;
#(
  parameter int INPUT_WIDTH = 12
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   sample_valid,
  input  logic [INPUT_WIDTH-1:0] wave_in,
  input  logic [3:0]             decay_shift,
  output logic [INPUT_WIDTH-2:0] env,
  output logic [INPUT_WIDTH-2:0] env_next,
  output logic                   env_update
);

  localparam int ENV_W = INPUT_WIDTH - 1;
  localparam logic [INPUT_WIDTH-1:0] MID = {1'b1, {(INPUT_WIDTH-1){1'b0}}};

  logic [INPUT_WIDTH-1:0] diff;
  logic [ENV_W-1:0]       rect;
  logic [ENV_W-1:0]       rect_q;
  logic [3:0]             shift_q;
  logic                   v1_q;
  logic [ENV_W-1:0]       decayed;

  // |wave_in - mid| needs one more bit than the envelope only for wave_in=0;
  // that single case clips to full scale.
  always_comb begin
    diff = '0;
    if (wave_in >= MID) begin
      diff = wave_in - MID;
    end else begin
      diff = MID - wave_in;
    end
    rect = diff[INPUT_WIDTH-1] ? '1 : diff[ENV_W-1:0];
  end

  // Stage 1: rectified sample plus the decay shift it must be processed with.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      rect_q  <= '0;
      shift_q <= '0;
    end else if (clear) begin
      v1_q    <= 1'b0;
      rect_q  <= '0;
      shift_q <= '0;
    end else begin
      v1_q <= sample_valid;
      if (sample_valid) begin
        rect_q  <= rect;
        shift_q <= decay_shift;
      end
    end
  end

  // Stage 2: peak-hold with decay. A zero shift would decay to nothing in one
  // step, so it is treated as "follow the rectifier" instead.
  always_comb begin
    decayed  = env - (env >> shift_q);
    env_next = env;
    if (shift_q == 4'd0) begin
      env_next = rect_q;
    end else if (rect_q > env) begin
      env_next = rect_q;
    end else begin
      env_next = decayed;
    end
  end

  assign env_update = v1_q && !clear;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      env <= '0;
    end else if (clear) begin
      env <= '0;
    end else if (env_update) begin
      env <= env_next;
    end
  end

endmodule

// File: rtl/demodulate.sv
// AM/FM demodulator top.
// AM: rectify + peak/decay envelope (am_envelope), left-aligned onto wave_out.
// FM: hysteretic zero-cross polarity tracker, period counter and lock FSM;
//     each locked rising crossing emits (full scale - period) on wave_out.
// Ports:
//   clk_in       clock, rising edge
//   RST          asynchronous active-low reset
//   Sel          1 = FM, 0 = AM; a change flushes both paths
//   in_valid     wave_in holds a new sample
//   wave_in      offset-binary carrier sample
//   decay_shift  AM envelope decay shift
//   wave_out     demodulated output, holds between updates
//   out_valid    one-cycle strobe when wave_out is updated
//   lock         FM: period tracked; AM: envelope nonzero
//
// FM lock FSM
//   state | meaning
//   ACQ   | no reference crossing yet (after reset, mode change or timeout)
//   MEAS  | one rising crossing seen, measuring first full period
//   LOCK  | period known; every rising crossing emits a new output
module demodulate
  import demodulate_pkg::*;
#(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int CNT_WIDTH    = 16,
  parameter int HYST         = 16
) (
  input  logic                    clk_in,
  input  logic                    RST,
  input  logic                    Sel,
  input  logic                    in_valid,
  input  logic [INPUT_WIDTH-1:0]  wave_in,
  input  logic [3:0]              decay_shift,
  output logic [OUTPUT_WIDTH-1:0] wave_out,
  output logic                    out_valid,
  output logic                    lock
);

  localparam int ENV_W = INPUT_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX  = '1;
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MAX  = '1;
  localparam logic [INPUT_WIDTH:0]    MID_EXT  = {2'b01, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic [INPUT_WIDTH:0]    HYST_EXT = (INPUT_WIDTH+1)'(HYST);

  logic sel_q;
  logic mode_known_q;
  logic mode_chg;
  logic accept;
  logic am_valid;
  logic fm_valid;

  // sel_q has no meaningful value straight out of reset, so the first edge
  // only learns the mode rather than treating it as a change.
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      sel_q        <= MODE_AM;
      mode_known_q <= 1'b0;
    end else begin
      sel_q        <= Sel;
      mode_known_q <= 1'b1;
    end
  end

  assign mode_chg = mode_known_q && (Sel != sel_q);
  assign accept   = in_valid && !mode_chg;
  assign am_valid = accept && (Sel == MODE_AM);
  assign fm_valid = accept && (Sel == MODE_FM);

  // ---------------------------------------------------------------- AM path
  logic [ENV_W-1:0]        am_env;
  logic [ENV_W-1:0]        am_env_next;
  logic                    am_upd;
  logic [OUTPUT_WIDTH-1:0] env_aligned;

  am_envelope #(
    .INPUT_WIDTH (INPUT_WIDTH)
  ) u_am_envelope (
    .clk_in       (clk_in),
    .rst_n        (RST),
    .clear        (mode_chg),
    .sample_valid (am_valid),
    .wave_in      (wave_in),
    .decay_shift  (decay_shift),
    .env          (am_env),
    .env_next     (am_env_next),
    .env_update   (am_upd)
  );

  generate
    if (OUTPUT_WIDTH > ENV_W) begin : g_pad
      assign env_aligned = {am_env_next, {(OUTPUT_WIDTH-ENV_W){1'b0}}};
    end else if (OUTPUT_WIDTH == ENV_W) begin : g_same
      assign env_aligned = am_env_next;
    end else begin : g_trunc
      assign env_aligned = am_env_next[ENV_W-1 -: OUTPUT_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------- FM path
  polarity_e              pol_q;
  polarity_e              pol_next;
  logic                   rising;
  logic [INPUT_WIDTH:0]   wave_ext;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   cnt_sat;
  fm_state_e              state_q;
  fm_state_e              state_next;
  logic                   fire;
  logic                   fire_q;
  logic [CNT_WIDTH-1:0]   period_q;
  logic                   fm_upd;
  logic [OUTPUT_WIDTH-1:0] period_clip;
  logic [OUTPUT_WIDTH-1:0] fm_value;

  assign wave_ext = {1'b0, wave_in};

  // Inside the +/-HYST band the polarity holds, so noise near mid-scale
  // cannot produce spurious crossings.
  always_comb begin
    pol_next = pol_q;
    if (fm_valid) begin
      if (wave_ext >= MID_EXT + HYST_EXT) begin
        pol_next = POS;
      end else if (wave_ext + HYST_EXT <= MID_EXT) begin
        pol_next = NEG;
      end
    end
  end

  assign rising  = fm_valid && is_rising(pol_q, pol_next);
  assign cnt_sat = (cnt_q == CNT_MAX);

  // The counter restarts at 1 on the crossing sample, so its value at the
  // next crossing equals the number of samples in the period.
  always_comb begin
    cnt_next = cnt_q;
    if (fm_valid) begin
      if (rising) begin
        cnt_next = CNT_WIDTH'(1);
      end else if (!cnt_sat) begin
        cnt_next = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // A saturated counter means the carrier was lost; it outranks a crossing
  // arriving in the same cycle since that period is not trustworthy.
  always_comb begin
    state_next = state_q;
    fire       = 1'b0;
    case (state_q)
      ACQ: begin
        if (rising) begin
          state_next = MEAS;
        end
      end
      MEAS: begin
        if (cnt_sat) begin
          state_next = ACQ;
        end else if (rising) begin
          state_next = LOCK;
          fire       = 1'b1;
        end
      end
      LOCK: begin
        if (cnt_sat) begin
          state_next = ACQ;
        end else if (rising) begin
          fire = 1'b1;
        end
      end
      default: state_next = ACQ;
    endcase
  end

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state_q  <= ACQ;
      pol_q    <= NEG;
      cnt_q    <= '0;
      fire_q   <= 1'b0;
      period_q <= '0;
    end else if (mode_chg) begin
      state_q <= ACQ;
      pol_q   <= NEG;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      pol_q   <= pol_next;
      cnt_q   <= cnt_next;
      fire_q  <= fire;
      if (fire) begin
        period_q <= cnt_q;
      end
    end
  end

  assign fm_upd = fire_q && !mode_chg;

  // Higher carrier frequency (shorter period) -> larger output.
  always_comb begin
    period_clip = OUTPUT_WIDTH'(period_q);
    if ({{OUTPUT_WIDTH{1'b0}}, period_q} > {{CNT_WIDTH{1'b0}}, OUT_MAX}) begin
      period_clip = OUT_MAX;
    end
    fm_value = OUT_MAX - period_clip;
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      wave_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= am_upd || fm_upd;
      if (am_upd) begin
        wave_out <= env_aligned;
      end else if (fm_upd) begin
        wave_out <= fm_value;
      end
    end
  end

  assign lock = (sel_q == MODE_FM) ? (state_q == LOCK) : (am_env != '0);

endmodule

// File: tb/tb_demodulate.sv
// Self-checking bench for demodulate: directed AM/FM vectors, a sample-level
// behavioural model scheduling expected outputs per clock edge, a per-cycle
// compare process, and hand-computed literal checks.
module tb_demodulate;

  localparam int IW  = 12;
  localparam int OW  = 12;
  localparam int CW  = 16;
  localparam int HY  = 16;
  localparam int MID = 2048;
  localparam int ST_ACQ  = 0;
  localparam int ST_MEAS = 1;
  localparam int ST_LOCK = 2;

  logic          clk_in = 1'b0;
  logic          RST = 1'b0;
  logic          Sel = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] wave_in = '0;
  logic [3:0]    decay_shift = '0;
  logic [OW-1:0] wave_out;
  logic          out_valid;
  logic          lock;

  demodulate #(
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .CNT_WIDTH    (CW),
    .HYST         (HY)
  ) dut (
    .clk_in      (clk_in),
    .RST         (RST),
    .Sel         (Sel),
    .in_valid    (in_valid),
    .wave_in     (wave_in),
    .decay_shift (decay_shift),
    .wave_out    (wave_out),
    .out_valid   (out_valid),
    .lock        (lock)
  );

  always #5 clk_in = ~clk_in;

  int edge_cnt = 0;
  always @(posedge clk_in) edge_cnt++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ------------------------------------------------ behavioural model
  bit m_sel = 1'b0;
  int m_env = 0;
  int m_cnt = 0;
  int m_st  = ST_ACQ;
  bit m_pol = 1'b0;      // 0 = below band, 1 = above band
  int ov_sched [int];    // edge -> expected wave_out on an out_valid cycle
  bit lock_chg [int];    // edge -> lock value from that edge on
  bit lock_cur = 1'b0;
  int wo_cur   = 0;

  task automatic model_clear();
    m_env = 0;
    m_cnt = 0;
    m_st  = ST_ACQ;
    m_pol = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    ov_sched.delete();
    lock_chg.delete();
    lock_cur = 1'b0;
    wo_cur   = 0;
  endtask

  // Effect of the clock edge number e given the inputs presented before it.
  task automatic model_edge(input int e, input bit s, input bit v, input int x, input int ds);
    int rect;
    bit pn;
    if (s != m_sel) begin
      m_sel = s;
      model_clear();
      if (ov_sched.exists(e)) ov_sched.delete(e);
      if (ov_sched.exists(e + 1)) ov_sched.delete(e + 1);
      if (lock_chg.exists(e + 1)) lock_chg.delete(e + 1);
      lock_chg[e] = 1'b0;
      return;
    end
    if (!v) return;
    if (!s) begin
      rect = (x >= MID) ? x - MID : MID - x;
      if (rect > MID - 1) rect = MID - 1;
      if (ds == 0 || rect > m_env) m_env = rect;
      else m_env = m_env - (m_env >> ds);
      ov_sched[e + 1] = m_env * 2;
      lock_chg[e + 1] = (m_env != 0);
    end else begin
      pn = m_pol;
      if (x >= MID + HY) pn = 1'b1;
      else if (x <= MID - HY) pn = 1'b0;
      if (!m_pol && pn) begin
        if (m_st == ST_ACQ) begin
          m_st = ST_MEAS;
        end else begin
          if (m_st == ST_MEAS) begin
            m_st = ST_LOCK;
            lock_chg[e] = 1'b1;
          end
          ov_sched[e + 1] = 4095 - ((m_cnt > 4095) ? 4095 : m_cnt);
        end
        m_cnt = 1;
      end else begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt == 65535 && m_st != ST_ACQ) begin
          m_st = ST_ACQ;
          lock_chg[e + 1] = 1'b0;
        end
      end
      m_pol = pn;
    end
  endtask

  // ------------------------------------------------ per-cycle compare
  always @(negedge clk_in) begin : cmp
    bit eov;
    if (lock_chg.exists(edge_cnt)) lock_cur = lock_chg[edge_cnt];
    eov = (ov_sched.exists(edge_cnt) != 0);
    if (eov) wo_cur = ov_sched[edge_cnt];
    check("out_valid", int'(out_valid), int'(eov));
    check("wave_out", int'(wave_out), wo_cur);
    check("lock", int'(lock), int'(lock_cur));
  end

  // ------------------------------------------------ stimulus helpers
  task automatic step(input bit v, input int x);
    in_valid = v;
    wave_in  = IW'(x);
    if (RST) model_edge(edge_cnt + 1, Sel, v, x, int'(decay_shift));
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MID);
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check("rst_wave_out", int'(wave_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_lock", int'(lock), 0);
    @(posedge clk_in);
    #1;
    RST = 1'b1;
  endtask

  task automatic fm_square(input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 4095);
    end
  endtask

  int car [16] = '{0, 383, 707, 924, 1000, 924, 707, 383,
                   0, -383, -707, -924, -1000, -924, -707, -383};

  initial begin
    int amp;
    int ph;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_wave_out", int'(wave_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_lock", int'(lock), 0);
    RST = 1'b1;

    // AM, decay_shift 0: envelope follows rectifier
    step(1'b1, 0);
    check("am_latency_1", int'(out_valid), 0);
    step(1'b0, MID);
    check("am_latency_2", int'(out_valid), 1);
    check("am_zero_clip", int'(wave_out), 4094);
    check("am_lock_on", int'(lock), 1);
    step(1'b1, MID);
    idle(2);
    check("am_mid", int'(wave_out), 0);
    check("am_lock_off", int'(lock), 0);
    step(1'b1, 3048);
    idle(2);
    check("am_3048", int'(wave_out), 2000);
    step(1'b1, 1000);
    idle(2);
    check("am_1000", int'(wave_out), 2096);
    decay_shift = 4'd1;
    step(1'b1, MID);
    idle(2);
    check("am_decay1", int'(wave_out), 1048);

    // AM, decay_shift 4: modulated carrier, 1/16 fs, with input gaps
    decay_shift = 4'd4;
    for (int n = 0; n < 384; n++) begin
      ph  = n % 128;
      amp = (ph < 64) ? 400 + ph * 12 : 400 + (127 - ph) * 12;
      step((n % 7) != 3, MID + (car[n % 16] * amp) / 1000);
    end
    idle(3);
    check("am_sweep_lock", int'(lock), 1);

    // Reset mid-stream with a sample in flight
    step(1'b1, 3000);
    pulse_reset();
    step(1'b1, 1000);
    check("post_rst_lat1", int'(out_valid), 0);
    step(1'b0, MID);
    check("post_rst_lat2", int'(out_valid), 1);
    check("post_rst_value", int'(wave_out), 2096);

    // FM: square carrier period 20
    Sel = 1'b1;
    step(1'b0, MID);
    fm_square(6);
    check("fm_lock", int'(lock), 1);
    check("fm_period20", int'(wave_out), 4075);

    // FM: carrier lost -> counter saturates, lock drops, output holds
    for (int i = 0; i < 65536; i++) step(1'b1, MID);
    check("fm_sat_lock", int'(lock), 0);
    check("fm_sat_hold", int'(wave_out), 4075);

    // FM: activity inside the hysteresis band never crosses
    pulse_reset();
    for (int i = 0; i < 200; i++) step(1'b1, (i % 2) ? 2056 : 2040);
    check("fm_band_lock", int'(lock), 0);

    // FM: over-long period clips to output 0, then normal period again
    fm_square(3);
    check("fm_relock", int'(lock), 1);
    for (int i = 0; i < 4200; i++) step(1'b1, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 4095);
    check("fm_clip", int'(wave_out), 0);
    fm_square(2);
    check("fm_after_clip", int'(wave_out), 4075);

    // Sel 1->0 in LOCK with a valid sample on the switch cycle
    decay_shift = 4'd0;
    Sel = 1'b0;
    step(1'b1, 3048);
    check("sw_lock", int'(lock), 0);
    check("sw_hold", int'(wave_out), 4075);
    check("sw_no_ov", int'(out_valid), 0);
    step(1'b1, 0);
    check("sw_am_lat1", int'(out_valid), 0);
    step(1'b0, MID);
    check("sw_am_lat2", int'(out_valid), 1);
    check("sw_am_value", int'(wave_out), 4094);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demodulate.md
DEMODULATE -- requirements
Module: demodulate

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 12, sample width of wave_in (unsigned offset-binary, mid-scale = 2^(INPUT_WIDTH-1)).
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 12, width of wave_out.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, FM period counter width.
REQ-004 SHALL have parameter HYST, default 16, FM zero-cross hysteresis in LSBs.
REQ-005 Port clk_in  input  1  single clock; all logic on rising edge.
REQ-006 Port RST  input  1  asynchronous, active-low reset.
REQ-007 Port Sel  input  1  mode: 1 = FM demodulate, 0 = AM demodulate.
REQ-008 Port in_valid  input  1  wave_in holds a new sample this cycle.
REQ-009 Port wave_in  input  INPUT_WIDTH  modulated carrier sample.
REQ-010 Port decay_shift  input  4  AM envelope decay shift, 0..15.
REQ-011 Port wave_out  output  OUTPUT_WIDTH  demodulated baseband, unsigned.
REQ-012 Port out_valid  output  1  one-cycle strobe, wave_out updated.
REQ-013 Port lock  output  1  FM: carrier period tracked; AM: envelope nonzero.

Function
REQ-014 Samples SHALL be consumed only when in_valid=1; no backpressure, every valid sample accepted.
REQ-015 AM: rect = |wave_in - mid|, (INPUT_WIDTH-1) bits, registered in stage 1.
REQ-016 AM stage 2: if rect > env then env <= rect, else env <= env - (env >> decay_shift); decay_shift=0 SHALL load rect each sample.
REQ-017 AM: wave_out = env left-aligned to OUTPUT_WIDTH (zero-pad or truncate LSBs); out_valid exactly 2 cycles after the accepting in_valid.
REQ-018 AM: lock = (env != 0).
REQ-019 FM polarity FSM: POS entered when wave_in >= mid+HYST, NEG when wave_in <= mid-HYST; inside band state holds.
REQ-020 FM period counter SHALL increment per valid sample, saturate at 2^CNT_WIDTH-1, and reset to 1 on each NEG->POS transition.
REQ-021 FM lock FSM states ACQ, MEAS, LOCK; reset/mode change -> ACQ; first rising crossing ACQ->MEAS; next rising crossing MEAS->LOCK; counter saturation from MEAS or LOCK -> ACQ.
REQ-022 FM: on each rising crossing in LOCK (including the MEAS->LOCK one), period latched; wave_out = (2^OUTPUT_WIDTH-1) - min(period, 2^OUTPUT_WIDTH-1); out_valid pulses 2 cycles after that sample.
REQ-023 FM: no out_valid outside LOCK; wave_out holds last value; lock = (state == LOCK).
REQ-024 Sel change SHALL, on the next cycle, clear env, counter, pipeline valids, set FSM to ACQ and polarity NEG; wave_out holds.
REQ-025 in_valid simultaneous with Sel change SHALL be discarded.
REQ-026 wave_in at exact mid-scale in AM SHALL give rect = 0; at 0 SHALL give rect = 2^(INPUT_WIDTH-1) clipped to 2^(INPUT_WIDTH-1)-1.

Reset
REQ-027 RST low SHALL asynchronously clear wave_out=0, out_valid=0, lock=0, env=0, counter=0, polarity NEG, FSM ACQ, pipeline valids 0.
REQ-028 Reset asserted mid-operation SHALL abandon any in-flight sample; first out_valid after release requires fresh samples.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (ACQ, MEAS, LOCK), polarity encoding (NEG, POS), and mode constants MODE_FM=1, MODE_AM=0.
REQ-030 Single sub-module am_envelope (rectifier + peak/decay, REQ-015..018); FM path and muxing in demodulate.

Verification
REQ-031 AM, decay_shift=4, 1 kHz-envelope 50%-depth carrier 1/16 fs, in_valid always 1 -> wave_out tracks envelope within 1/16 FS, lock=1 after first nonzero sample.
REQ-032 FM, square carrier 0/4095 period 20 samples -> ACQ->MEAS->LOCK on 1st/2nd rising edge, then wave_out=4075 each 20 samples, out_valid 2 cycles after edge.
REQ-033 FM, wave_in constant 2048 for 65536 valid samples after LOCK -> counter saturates, lock falls, out_valid stops, wave_out holds 4075.
REQ-034 FM, signal toggling 2040/2056 with HYST=16 -> polarity never changes, FSM stays ACQ.
REQ-035 Sel 1->0 in LOCK with in_valid=1 same cycle -> that sample dropped, lock=0 next cycle, env=0, AM out_valid resumes 2 cycles after next valid sample.
REQ-036 RST low for 1 cycle mid-stream, AM mode -> all outputs 0 immediately, out_valid first high 2 cycles after first post-reset valid sample.
